// File: rtl/rf_seq_pkg.sv
// Shared definitions for the register-file op sequencer: opcodes, FSM states, instruction fields.
// Instruction layout is op[7:6] rd[5:4] ra[3:2] rb[1:0]; LDI reuses {ra,rb} as its immediate.
package rf_seq_pkg;

   localparam int DW_DEF = 4;
   localparam int AW_DEF = 2;
   localparam int IW     = 8;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_LDI = 2'b11;

   localparam int OP_MSB = 7;
   localparam int OP_LSB = 6;
   localparam int RD_MSB = 5;
   localparam int RD_LSB = 4;
   localparam int RA_MSB = 3;
   localparam int RA_LSB = 2;
   localparam int RB_MSB = 1;
   localparam int RB_LSB = 0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_EXEC  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/rf_seq_alu.sv
// Combinational ALU for the sequencer; c is carry (ADD) or borrow (SUB, a < b), else 0.
// Zero latency, no flow control.
module rf_seq_alu
   import rf_seq_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic [1:0]    op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [DW-1:0] imm,
   output logic [DW-1:0] y,
   output logic          c
);

   logic [DW:0] sum;
   logic [DW:0] diff;

   always_comb begin
      sum  = {1'b0, a} + {1'b0, b};
      diff = {1'b0, a} - {1'b0, b};
      y    = '0;
      c    = 1'b0;
      case (op)
         OP_ADD: begin
            y = sum[DW-1:0];
            c = sum[DW];
         end
         OP_SUB: begin
            y = diff[DW-1:0];
            c = diff[DW];
         end
         OP_AND: y = a & b;
         OP_LDI: y = imm;
      endcase
   end

endmodule

// File: rtl/rf_op_sequencer.sv
// Five-state sequencer (IDLE/READ/EXEC/WRITE/DONE): accept -> RF write 3 edges later, done 1 cycle after;
// in_ready only in IDLE so one instruction per 5 cycles. RF_SEQ_FLAGS_EN adds registered flag_z/flag_c.
module rf_op_sequencer
   import rf_seq_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [IW-1:0] instr,
   output logic [AW-1:0] rf_ra,
   output logic [AW-1:0] rf_rb,
   input  logic [DW-1:0] rf_a,
   input  logic [DW-1:0] rf_b,
   output logic          rf_re,
   output logic [AW-1:0] rf_wr,
   output logic [DW-1:0] rf_wrd,
   output logic          done,
   output logic [DW-1:0] result
`ifdef RF_SEQ_FLAGS_EN
   ,
   output logic          flag_z,
   output logic          flag_c
`endif
);

   state_t        state;
   logic [IW-1:0] instr_q;
   logic [DW-1:0] opa_q;
   logic [DW-1:0] opb_q;
   logic [DW-1:0] res_q;
   logic [DW-1:0] alu_y;
   logic          alu_c;

   // Gating with reset keeps a reset landing in WRITE from committing anything.
   assign in_ready = (state == S_IDLE) && !reset;
   assign rf_re    = (state == S_WRITE) && !reset;
   assign rf_ra    = AW'(instr_q[RA_MSB:RA_LSB]);
   assign rf_rb    = AW'(instr_q[RB_MSB:RB_LSB]);
   assign rf_wr    = AW'(instr_q[RD_MSB:RD_LSB]);
   assign rf_wrd   = res_q;

   rf_seq_alu #(.DW(DW)) u_alu (
      .op  (instr_q[OP_MSB:OP_LSB]),
      .a   (opa_q),
      .b   (opb_q),
      .imm (DW'(instr_q[RA_MSB:RB_LSB])),
      .y   (alu_y),
      .c   (alu_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         instr_q <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         done    <= 1'b0;
         result  <= '0;
`ifdef RF_SEQ_FLAGS_EN
         flag_z  <= 1'b0;
         flag_c  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  instr_q <= instr;
                  state   <= S_READ;
               end
            end
            S_READ: begin
               opa_q <= rf_a;
               opb_q <= rf_b;
               state <= S_EXEC;
            end
            S_EXEC: begin
               res_q  <= alu_y;
`ifdef RF_SEQ_FLAGS_EN
               flag_z <= (alu_y == '0);
               flag_c <= alu_c;
`endif
               state  <= S_WRITE;
            end
            S_WRITE: begin
               done   <= 1'b1;
               result <= res_q;
               state  <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifndef RF_SEQ_FLAGS_EN
   logic unused_alu_c;
   assign unused_alu_c = alu_c;
`endif

endmodule

// File: doc/rf_op_sequencer.md
Name: rf_op_sequencer

Overview:
- Multi-cycle controller that sequences the 4-entry x 4-bit register file (two read ports, one write port with write enable).
- Accepts one 8-bit register-to-register instruction per valid/ready handshake and drives the RF read addresses.
- Computes the result with an internal 4-bit ALU and commits it through the RF write port.
- Sits between the instruction source (test driver or future fetch unit) and the register file.

Parameters:
- DW, 4, datapath/register width (RF data width).
- AW, 2, register address width (4 registers).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present on instr.
- in_ready  out  1  sequencer can accept an instruction (IDLE only).
- instr  in  8  instruction: op[7:6], rd[5:4], ra[3:2], rb[1:0].
- rf_ra  out  AW  RF read address A.
- rf_rb  out  AW  RF read address B.
- rf_a  in  DW  RF read data A (combinational from rf_ra).
- rf_b  in  DW  RF read data B (combinational from rf_rb).
- rf_re  out  1  RF write enable.
- rf_wr  out  AW  RF write address.
- rf_wrd  out  DW  RF write data.
- done  out  1  one-cycle pulse; write committed on the preceding edge.
- result  out  DW  last committed value, held until next commit.

Behaviour:
- Opcodes:
  - 00 ADD: rd = ra + rb.
  - 01 SUB: rd = ra - rb.
  - 10 AND: rd = ra & rb.
  - 11 LDI: rd = {ra,rb} as a 4-bit immediate; no RF read used.
- Arithmetic is mod 2^DW. The internal 5-bit sum/difference keeps bit 4 as carry (ADD) or borrow (SUB, set when ra < rb).
- FSM states: IDLE -> READ -> EXEC -> WRITE -> DONE -> IDLE. Every transition is unconditional except IDLE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch instr and go to READ. Otherwise stay.
  - READ: rf_ra=ra, rf_rb=rb; capture rf_a and rf_b into operand registers.
  - EXEC: ALU computes from the operand registers (LDI uses the immediate); result registered into res_q.
  - WRITE: rf_re=1, rf_wr=rd, rf_wrd=res_q. The RF captures on the closing edge.
  - DONE: done=1 and result=res_q.
- Latency: handshake edge T -> write edge T+3 -> done high during cycle T+4 -> in_ready high again at T+5. Throughput is one instruction per 5 cycles.
- rf_re is high only in WRITE: exactly one write per instruction, never two.
- rf_ra/rf_rb hold the latched ra/rb in all states after acceptance. Both are 0 after reset until the first acceptance.
- in_valid while not IDLE is ignored; upstream must hold instr until accepted.
- rd equal to ra or rb is legal; sources are read in READ, before WRITE.
- Reset values: state=IDLE, rf_re=0, rf_wr=0, rf_wrd=0, done=0, result=0, latched instr=0.
- in_ready is forced to 0 during any cycle with reset=1.
- Reset mid-operation (any state): the next state is IDLE and no write is issued. A WRITE-state cycle with reset=1 drives rf_re=0; the RF clears concurrently.

Optional Feature:
- Macro: RF_SEQ_FLAGS_EN.
- When defined, add outputs flag_z (1 bit) and flag_c (1 bit).
  - Both are registered in EXEC and updated at the same edge as res_q.
  - flag_z = (result == 0). flag_c = carry/borrow for ADD/SUB; flag_c = 0 for AND/LDI.
  - Both reset to 0 and hold between instructions.
- When not defined, these ports and registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package rf_seq_pkg holds:
  - opcode localparams OP_ADD/OP_SUB/OP_AND/OP_LDI;
  - FSM state encoding (3 bits: S_IDLE, S_READ, S_EXEC, S_WRITE, S_DONE);
  - instruction field bit positions.
- Natural sub-module: rf_seq_alu, purely combinational. Inputs: op, a, b, imm. Outputs: y[DW-1:0], c.
- The FSM and handshake stay in rf_op_sequencer. The bench instantiates the register file alongside it.

Test Plan:
- Reset, then in_valid=1 instr=0xD5 (LDI R1,5) -> in_ready drops next cycle; rf_re=1, rf_wr=1, rf_wrd=5 in WRITE; done pulses once 4 cycles after acceptance; RF R1=5.
- Then 0xE3 (LDI R2,3), then 0x36 (ADD R3=R1+R2) -> RF R3=8, result=8, flag_z=0, flag_c=0.
- 0x49 (SUB R0=R2-R1) -> R0=0xE, flag_c=1 (borrow).
- Then 0xDF (LDI R1,0xF) and 0x15 (ADD R1=R1+R1) -> R1=0xE, flag_c=1; rd==ra read-before-write is correct.
- Hold in_valid=1 with a second instr during busy -> exactly one accept per IDLE; no extra rf_re pulses; back-to-back accept spacing is 5 cycles.
- Assert reset during WRITE of 0x36 -> rf_re=0 that cycle, R3 not written (reads 0), state IDLE, done never pulses, in_ready=1 after reset drops.
